// File: rtl/cpu_microsequencer.sv
// SAP-1 style microsequencer: T-state counter plus opcode/flag decode into a registered control word.
// Optional build macro MICROSEQ_EARLY_END_EN returns to T0 right after an opcode's last active step.
module cpu_microsequencer #(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf_in,
    input  logic                zf_in,
    input  logic                step_en,
    output logic [14:0]         ctrl,
    output logic [2:0]          t_state,
    output logic                halted,
    output logic                fetch
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [14:0] IDLE   = 15'h0FA3;
    localparam logic [2:0]  T_LAST = 3'(NUM_T - 1);

    localparam int CP = 14, EP = 13, LP = 12, N_LMA = 11, N_LMD = 10, N_CE = 9, N_LR = 8;
    localparam int N_LI = 7, EI = 6, N_LA = 5, EA = 4, SUB = 3, EU = 2, N_LB = 1, N_LO = 0;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF;

    logic [1:0]  state;
    logic [3:0]  op;
    logic [2:0]  t_next;
    logic [2:0]  t_go;
    logic [14:0] word;

    // Any nonzero bit above the decoded nibble turns the instruction into a NOP.
    always_comb begin
        op = ((opcode >> 4) == '0) ? opcode[3:0] : OP_NOP;
    end

`ifdef MICROSEQ_EARLY_END_EN
    logic [2:0] last_step;

    always_comb begin
        case (op)
            OP_LDA:                 last_step = 3'd4;
            OP_ADD, OP_SUB, OP_STA: last_step = 3'd5;
            default:                last_step = 3'd3;
        endcase
    end
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        t_next = (t_state == T_LAST) ? 3'd0 : t_state + 3'd1;
`ifdef MICROSEQ_EARLY_END_EN
        if (t_state == last_step) t_next = 3'd0;
`endif
        // Coming out of reset, the first enabled edge presents T0 rather than skipping it.
        t_go = (state == ST_START) ? 3'd0 : t_next;
    end

    // Word for the step about to be entered; flags only matter for the T3 word.
    always_comb begin
        word = IDLE;
        case (t_go)
            3'd0: begin word[EP] = 1'b1; word[N_LMA] = 1'b0; end
            3'd1: word[CP] = 1'b1;
            3'd2: begin word[N_CE] = 1'b0; word[N_LI] = 1'b0; end
            3'd3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin word[EI] = 1'b1; word[N_LMA] = 1'b0; end
                    OP_LDI: begin word[EI] = 1'b1; word[N_LA] = 1'b0; end
                    OP_JMP: begin word[EI] = 1'b1; word[LP] = 1'b1; end
                    OP_JC:  if (cf_in) begin word[EI] = 1'b1; word[LP] = 1'b1; end
                    OP_JZ:  if (zf_in) begin word[EI] = 1'b1; word[LP] = 1'b1; end
                    OP_OUT: begin word[EA] = 1'b1; word[N_LO] = 1'b0; end
                    default: ;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_LDA:         begin word[N_CE] = 1'b0; word[N_LA] = 1'b0; end
                    OP_ADD, OP_SUB: begin word[N_CE] = 1'b0; word[N_LB] = 1'b0; end
                    OP_STA:         begin word[EA] = 1'b1; word[N_LMD] = 1'b0; end
                    default: ;
                endcase
            end
            3'd5: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        word[EU]   = 1'b1;
                        word[N_LA] = 1'b0;
                        word[SUB]  = (op == OP_SUB);
                    end
                    OP_STA: word[N_LR] = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_START;
            t_state <= 3'd0;
            ctrl    <= IDLE;
        end else if (state != ST_HALT && step_en) begin
            if (state == ST_RUN && t_state == 3'd2 && op == OP_HLT) begin
                state   <= ST_HALT;
                t_state <= 3'd3;
                ctrl    <= IDLE;
            end else begin
                state   <= ST_RUN;
                t_state <= t_go;
                ctrl    <= word;
            end
        end
    end

    assign halted = (state == ST_HALT);
    assign fetch  = (t_state < 3'd3);

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Scoreboard bench for cpu_microsequencer: stimulus pushes expected state, a monitor pops and compares.
`timescale 1ns/1ps
module tb_cpu_microsequencer;

    localparam int NUM_T = 6;

    // Hand-computed control words, bits [14]Cp .. [0]nLo, idle = 15'h0FA3.
    localparam logic [14:0] IDLE   = 15'h0FA3;
    localparam logic [14:0] W_T0   = 15'h27A3;  // Ep high, nLma low
    localparam logic [14:0] W_T1   = 15'h4FA3;
    localparam logic [14:0] W_T2   = 15'h0D23;
    localparam logic [14:0] W_MAR3 = 15'h07E3;  // Ei, nLma low (LDA/ADD/SUB/STA)
    localparam logic [14:0] W_LDA4 = 15'h0D83;
    localparam logic [14:0] W_ADD4 = 15'h0DA1;
    localparam logic [14:0] W_ADD5 = 15'h0F87;
    localparam logic [14:0] W_SUB5 = 15'h0F8F;
    localparam logic [14:0] W_STA4 = 15'h0BB3;
    localparam logic [14:0] W_STA5 = 15'h0EA3;
    localparam logic [14:0] W_LDI3 = 15'h0FC3;
    localparam logic [14:0] W_JMP3 = 15'h1FE3;
    localparam logic [14:0] W_OUT3 = 15'h0FB2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        cf_in = 1'b0;
    logic        zf_in = 1'b0;
    logic        step_en = 1'b0;
    logic [14:0] ctrl;
    logic [2:0]  t_state;
    logic        halted;
    logic        fetch;

    typedef struct {
        int          id;
        logic [2:0]  t;
        logic [14:0] c;
        logic        h;
        logic        f;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int next_id = 0;

    always #5 clk = ~clk;

    cpu_microsequencer #(.OPCODE_W(4), .NUM_T(NUM_T)) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .cf_in   (cf_in),
        .zf_in   (zf_in),
        .step_en (step_en),
        .ctrl    (ctrl),
        .t_state (t_state),
        .halted  (halted),
        .fetch   (fetch)
    );

    task automatic push(input logic [2:0] t, input logic [14:0] c, input logic h);
        sb_item_t it;
        it.id = next_id;
        it.t  = t;
        it.c  = c;
        it.h  = h;
        it.f  = (t < 3'd3);
        next_id++;
        sb_q.push_back(it);
    endtask

    // One clock of stimulus; the expectation describes the DUT after the following rising edge.
    task automatic step(input logic en, input logic [3:0] op, input logic cf, input logic zf,
                        input logic [2:0] t, input logic [14:0] c, input logic h);
        @(negedge clk);
        rst     = 1'b0;
        step_en = en;
        opcode  = op;
        cf_in   = cf;
        zf_in   = zf;
        push(t, c, h);
    endtask

    // Reset takes effect without a clock edge; the monitor also wakes on rst.
    task automatic assert_reset();
        @(negedge clk);
        push(3'd0, IDLE, 1'b0);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic fetch_steps(input logic [3:0] op);
        step(1'b1, op, 1'b0, 1'b0, 3'd1, W_T1, 1'b0);
        step(1'b1, op, 1'b0, 1'b0, 3'd2, W_T2, 1'b0);
    endtask

    // Remaining idle steps of an instruction (none when early end is built in), then T0.
    task automatic tail(input int from_t, input logic [3:0] op);
`ifndef MICROSEQ_EARLY_END_EN
        for (int t = from_t; t < NUM_T; t++) step(1'b1, op, 1'b0, 1'b0, 3'(t), IDLE, 1'b0);
`endif
        step(1'b1, op, 1'b0, 1'b0, 3'd0, W_T0, 1'b0);
    endtask

    initial begin : monitor
        sb_item_t it;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks++;
                if (ctrl !== it.c || t_state !== it.t || halted !== it.h || fetch !== it.f) begin
                    errors++;
                    $display("FAIL step%0d: got ctrl=%h t_state=%0d halted=%b fetch=%b, expected ctrl=%h t_state=%0d halted=%b fetch=%b",
                             it.id, ctrl, t_state, halted, fetch, it.c, it.t, it.h, it.f);
                end
            end
        end
    end

    initial begin : stimulus
        assert_reset();
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, W_T0, 1'b0);

        // ADD full sequence and wrap
        fetch_steps(4'h2);
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd3, W_MAR3, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd4, W_ADD4, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd5, W_ADD5, 1'b0);
        tail(6, 4'h2);

        // ADD aborted by reset in T4
        fetch_steps(4'h2);
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd3, W_MAR3, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0, 3'd4, W_ADD4, 1'b0);
        assert_reset();
        step(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, W_T0, 1'b0);

        // JC taken: cf only matters at the T2->T3 edge
        step(1'b1, 4'h7, 1'b1, 1'b0, 3'd1, W_T1, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b0, 3'd2, W_T2, 1'b0);
        step(1'b1, 4'h7, 1'b1, 1'b0, 3'd3, W_JMP3, 1'b0);
        tail(4, 4'h7);

        // JC not taken although cf was high earlier
        step(1'b1, 4'h7, 1'b1, 1'b0, 3'd1, W_T1, 1'b0);
        step(1'b1, 4'h7, 1'b1, 1'b0, 3'd2, W_T2, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b1, 3'd3, IDLE, 1'b0);
        tail(4, 4'h7);

        // JZ taken, then JZ not taken with carry set
        fetch_steps(4'h8);
        step(1'b1, 4'h8, 1'b0, 1'b1, 3'd3, W_JMP3, 1'b0);
        tail(4, 4'h8);
        fetch_steps(4'h8);
        step(1'b1, 4'h8, 1'b1, 1'b0, 3'd3, IDLE, 1'b0);
        tail(4, 4'h8);

        // LDA with a 5-clock freeze at T2
        fetch_steps(4'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h1, i[0], 1'b0, 3'd2, W_T2, 1'b0);
        step(1'b1, 4'h1, 1'b0, 1'b0, 3'd3, W_MAR3, 1'b0);
        step(1'b1, 4'h1, 1'b0, 1'b0, 3'd4, W_LDA4, 1'b0);
        tail(5, 4'h1);

        // LDI, JMP, OUT: single execute step
        fetch_steps(4'h5);
        step(1'b1, 4'h5, 1'b0, 1'b0, 3'd3, W_LDI3, 1'b0);
        tail(4, 4'h5);
        fetch_steps(4'h6);
        step(1'b1, 4'h6, 1'b0, 1'b0, 3'd3, W_JMP3, 1'b0);
        tail(4, 4'h6);
        fetch_steps(4'hE);
        step(1'b1, 4'hE, 1'b0, 1'b0, 3'd3, W_OUT3, 1'b0);
        tail(4, 4'hE);

        // STA and SUB: three execute steps
        fetch_steps(4'h4);
        step(1'b1, 4'h4, 1'b0, 1'b0, 3'd3, W_MAR3, 1'b0);
        step(1'b1, 4'h4, 1'b0, 1'b0, 3'd4, W_STA4, 1'b0);
        step(1'b1, 4'h4, 1'b0, 1'b0, 3'd5, W_STA5, 1'b0);
        tail(6, 4'h4);
        fetch_steps(4'h3);
        step(1'b1, 4'h3, 1'b0, 1'b0, 3'd3, W_MAR3, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0, 3'd4, W_ADD4, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0, 3'd5, W_SUB5, 1'b0);
        tail(6, 4'h3);

        // NOP and an undefined opcode
        fetch_steps(4'h0);
        step(1'b1, 4'h0, 1'b1, 1'b1, 3'd3, IDLE, 1'b0);
        tail(4, 4'h0);
        fetch_steps(4'hA);
        step(1'b1, 4'hA, 1'b1, 1'b1, 3'd3, IDLE, 1'b0);
        tail(4, 4'hA);

        // HLT: latched for 20 clocks regardless of step_en/opcode, cleared only by reset
        fetch_steps(4'hF);
        step(1'b1, 4'hF, 1'b0, 1'b0, 3'd3, IDLE, 1'b1);
        for (int i = 0; i < 20; i++) step(i[0], 4'(i), i[1], i[2], 3'd3, IDLE, 1'b1);
        assert_reset();
        step(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, W_T0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0, 3'd1, W_T1, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
